// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 stream multiplexer: mode encodings and default sizing.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   DEFAULT_N  = 4;
  localparam int   DEFAULT_W  = 64;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above 'last', wrapping modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // Offsets 1..N so 'last' itself is checked last and only if nobody else asks.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage sustaining one word per cycle.
module stream_mux_nx1
  import mux_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  parameter  int W  = DEFAULT_W,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  // Handshake: a word moves on any port when its valid and ready are both high at
  // a rising clk edge; valid never depends on ready, ready may depend on valid.

  logic [W-1:0]  out_data_q,   out_data_d;
  logic [SW-1:0] out_chan_q,   out_chan_d;
  logic          out_valid_q,  out_valid_d;
  logic [SW-1:0] last_grant_q, last_grant_d;

  logic          load;
  logic          rr_valid;
  logic [SW-1:0] rr_idx;
  logic          fix_valid;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic          xfer_in;

  rr_arbiter #(.N(N)) u_rr (
    .req       (in_valid),
    .last      (last_grant_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Reset gates load so in_ready stays low while reset is held.
  assign load      = !reset && (!out_valid_q || out_ready);
  assign fix_valid = (int'(sel) < N) ? in_valid[sel] : 1'b0;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode == MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end else if (fix_valid) begin
      grant_valid = 1'b1;
      grant_idx   = sel;
    end
  end

  assign xfer_in = load && grant_valid;

  always_comb begin
    in_ready = '0;
    if (xfer_in) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (xfer_in) begin
      out_data_d  = in_data[int'(grant_idx)*W +: W];
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SW'(N - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
